// File: rtl/mult_operand_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : mult_seq_pkg                                               |
// | Description : Shared types, constants and helpers for the multiplier     |
// |               operand sequencer.                                         |
// |               sew_e    - element-width encoding                          |
// |               get_byte - extract byte idx (0..3) from a 32-bit word      |
// |               STEPS_16 / STEPS_32 - partial-product steps per element    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package mult_seq_pkg;

   typedef enum logic [1:0] {
      SEW_8    = 2'b00,
      SEW_16   = 2'b01,
      SEW_32   = 2'b10,
      SEW_RSVD = 2'b11
   } sew_e;

   localparam int STEPS_16 = 4;
   localparam int STEPS_32 = 16;

   function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] idx);
      return word[{idx, 3'b000} +: 8];
   endfunction

endpackage
`default_nettype wire

// File: rtl/mult_operand_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : mult_operand_sequencer_if                                  |
// | Description : Bundles the sequencer data/control inputs and operand      |
// |               outputs. slave = sequencer side, master = driver side.     |
// |   data_in_A/B  (32) source words          sew (2) element width          |
// |   enable_2bit/4bit  counter advance       count_16bit (2) / _32bit (4)   |
// |   mult1_A/B, mult2_A/B (8) operand pairs  prod1/2 (16) if MULT_PRODUCT_EN|
// | Config      : MULT_PRODUCT_EN adds the prod1/prod2 signals               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface mult_operand_sequencer_if;

   logic [31:0] data_in_A;
   logic [31:0] data_in_B;
   logic [1:0]  sew;
   logic        enable_2bit;
   logic        enable_4bit;
   logic [1:0]  count_16bit;
   logic [3:0]  count_32bit;
   logic [7:0]  mult1_A;
   logic [7:0]  mult1_B;
   logic [7:0]  mult2_A;
   logic [7:0]  mult2_B;
`ifdef MULT_PRODUCT_EN
   logic [15:0] prod1;
   logic [15:0] prod2;

   modport slave (
      input  data_in_A, data_in_B, sew, enable_2bit, enable_4bit,
      output count_16bit, count_32bit, mult1_A, mult1_B, mult2_A, mult2_B,
      output prod1, prod2
   );

   modport master (
      output data_in_A, data_in_B, sew, enable_2bit, enable_4bit,
      input  count_16bit, count_32bit, mult1_A, mult1_B, mult2_A, mult2_B,
      input  prod1, prod2
   );
`else
   modport slave (
      input  data_in_A, data_in_B, sew, enable_2bit, enable_4bit,
      output count_16bit, count_32bit, mult1_A, mult1_B, mult2_A, mult2_B
   );

   modport master (
      output data_in_A, data_in_B, sew, enable_2bit, enable_4bit,
      input  count_16bit, count_32bit, mult1_A, mult1_B, mult2_A, mult2_B
   );
`endif

endinterface
`default_nettype wire

// File: rtl/mult_operand_sequencer_wrap_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : wrap_counter                                               |
// | Description : Free-running step counter with enable; wraps naturally     |
// |               from all-ones back to zero.                                |
// |   clk (1) clock, reset (1) async active-high, enable (1) advance,        |
// |   count (WIDTH) current step                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module wrap_counter #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (enable) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/mult_operand_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mult_operand_sequencer                                     |
// | Description : Slices two 32-bit source words into bytes and presents one |
// |               operand pair per cycle to each of two 8x8 multipliers,     |
// |               stepping through SEW=8/16/32 partial products.             |
// |   clk (1) clock, reset (1) async active-high                             |
// |   bus (mult_operand_sequencer_if.slave) data, control, operands          |
// | Config      : MULT_PRODUCT_EN - add two unsigned 8x8 multipliers driving |
// |               bus.prod1 / bus.prod2                                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mult_operand_sequencer
   import mult_seq_pkg::*;
(
   input  logic                           clk,
   input  logic                           reset,
   mult_operand_sequencer_if.slave        bus
);

   logic [1:0] c;
   logic [3:0] k;
   sew_e       sew_sel;
   logic [7:0] m1_a, m1_b, m2_a, m2_b;

   wrap_counter #(.WIDTH($clog2(STEPS_16))) u_count_16 (
      .clk    (clk),
      .reset  (reset),
      .enable (bus.enable_2bit),
      .count  (c)
   );

   wrap_counter #(.WIDTH($clog2(STEPS_32))) u_count_32 (
      .clk    (clk),
      .reset  (reset),
      .enable (bus.enable_4bit),
      .count  (k)
   );

   assign sew_sel = sew_e'(bus.sew);

   always_comb begin
      m1_a = 8'h00;
      m1_b = 8'h00;
      m2_a = 8'h00;
      m2_b = 8'h00;
      case (sew_sel)
         SEW_8: begin
            // c[0] picks the lower or upper byte pair; c[1] is a don't-care.
            m1_a = get_byte(bus.data_in_A, {c[0], 1'b0});
            m1_b = get_byte(bus.data_in_B, {c[0], 1'b0});
            m2_a = get_byte(bus.data_in_A, {c[0], 1'b1});
            m2_b = get_byte(bus.data_in_B, {c[0], 1'b1});
         end
         SEW_16: begin
            // c[1] walks the A half, c[0] the B half of each 16-bit element.
            m1_a = get_byte(bus.data_in_A, {1'b0, c[1]});
            m1_b = get_byte(bus.data_in_B, {1'b0, c[0]});
            m2_a = get_byte(bus.data_in_A, {1'b1, c[1]});
            m2_b = get_byte(bus.data_in_B, {1'b1, c[0]});
         end
         SEW_32: begin
            // Single element: multiplier 2 sits idle at zero.
            m1_a = get_byte(bus.data_in_A, k[3:2]);
            m1_b = get_byte(bus.data_in_B, k[1:0]);
         end
         default: ;
      endcase
   end

   assign bus.count_16bit = c;
   assign bus.count_32bit = k;
   assign bus.mult1_A     = m1_a;
   assign bus.mult1_B     = m1_b;
   assign bus.mult2_A     = m2_a;
   assign bus.mult2_B     = m2_b;

`ifdef MULT_PRODUCT_EN
   assign bus.prod1 = {8'h00, m1_a} * {8'h00, m1_b};
   assign bus.prod2 = {8'h00, m2_a} * {8'h00, m2_b};
`endif

endmodule
`default_nettype wire

// File: tb/tb_mult_operand_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mult_operand_sequencer                                  |
// | Description : Self-checking bench for mult_operand_sequencer. Expected   |
// |               outputs are queued when stimulus is driven and popped when |
// |               the DUT outputs are sampled.                               |
// | Config      : MULT_PRODUCT_EN also checks prod1/prod2                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mult_operand_sequencer;
   import mult_seq_pkg::*;

   typedef struct {
      string       name;
      logic [37:0] snap;   // {count_16bit, count_32bit, m1A, m1B, m2A, m2B}
      logic [15:0] p1;
      logic [15:0] p2;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   passed = 0;
   int   total  = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   mult_operand_sequencer_if bus();

   mult_operand_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   function automatic logic [37:0] snapshot();
      return {bus.count_16bit, bus.count_32bit, bus.mult1_A, bus.mult1_B, bus.mult2_A, bus.mult2_B};
   endfunction

   // Literal expectation; products follow from the operands.
   function automatic exp_t lit(string name, logic [1:0] c, logic [3:0] k,
                                logic [7:0] a1, logic [7:0] b1, logic [7:0] a2, logic [7:0] b2);
      exp_t e;
      e.name = name;
      e.snap = {c, k, a1, b1, a2, b2};
      e.p1   = 16'(a1) * 16'(b1);
      e.p2   = 16'(a2) * 16'(b2);
      return e;
   endfunction

   // Reference model over the fixed test data A=11223344, B=55667788.
   function automatic exp_t model(string name, logic [1:0] sew, logic [1:0] c, logic [3:0] k);
      logic [7:0] a [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
      logic [7:0] b [4] = '{8'h88, 8'h77, 8'h66, 8'h55};
      logic [7:0] a1 = 8'h00, b1 = 8'h00, a2 = 8'h00, b2 = 8'h00;
      int base;
      case (sew)
         2'b00: begin
            base = c[0] ? 2 : 0;
            a1 = a[base]; b1 = b[base]; a2 = a[base + 1]; b2 = b[base + 1];
         end
         2'b01: begin
            a1 = a[int'(c[1])]; b1 = b[int'(c[0])];
            a2 = a[2 + int'(c[1])]; b2 = b[2 + int'(c[0])];
         end
         2'b10: begin
            a1 = a[int'(k) / 4]; b1 = b[int'(k) % 4];
         end
         default: ;
      endcase
      return lit(name, c, k, a1, b1, a2, b2);
   endfunction

   task automatic test_reset();
      exp_t e;
      reset = 1'b1;
      bus.data_in_A = 32'h11223344;
      bus.data_in_B = 32'h55667788;
      bus.sew = 2'b00;
      bus.enable_2bit = 1'b1;
      bus.enable_4bit = 1'b1;
      sb.push_back(lit("reset_hold", 2'd0, 4'd0, 8'h44, 8'h88, 8'h33, 8'h77));
      repeat (3) @(posedge clk);
      #1;
      e = sb.pop_front();
      total++;
      if (snapshot() !== e.snap) $display("FAIL %s: got %h expected %h", e.name, snapshot(), e.snap);
      else passed++;
`ifdef MULT_PRODUCT_EN
      total++;
      if ({bus.prod1, bus.prod2} !== {e.p1, e.p2})
         $display("FAIL %s_prod: got %h expected %h", e.name, {bus.prod1, bus.prod2}, {e.p1, e.p2});
      else passed++;
`endif
      bus.enable_2bit = 1'b0;
      bus.enable_4bit = 1'b0;
      reset = 1'b0;
   endtask

   task automatic test_sew8();
      exp_t e;
      bus.sew = 2'b00;
      bus.enable_2bit = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         if (i % 2 == 1) sb.push_back(lit("sew8_step", 2'(i % 4), 4'd0, 8'h22, 8'h66, 8'h11, 8'h55));
         else            sb.push_back(lit("sew8_step", 2'(i % 4), 4'd0, 8'h44, 8'h88, 8'h33, 8'h77));
         @(posedge clk);
         #1;
         e = sb.pop_front();
         total++;
         if (snapshot() !== e.snap) $display("FAIL %s%0d: got %h expected %h", e.name, i, snapshot(), e.snap);
         else passed++;
`ifdef MULT_PRODUCT_EN
         total++;
         if ({bus.prod1, bus.prod2} !== {e.p1, e.p2})
            $display("FAIL %s%0d_prod: got %h expected %h", e.name, i, {bus.prod1, bus.prod2}, {e.p1, e.p2});
         else passed++;
`endif
      end
      bus.enable_2bit = 1'b0;
   endtask

   task automatic test_sew16();
      exp_t e;
      logic [7:0] t1a [4] = '{8'h44, 8'h44, 8'h33, 8'h33};
      logic [7:0] t1b [4] = '{8'h88, 8'h77, 8'h88, 8'h77};
      logic [7:0] t2a [4] = '{8'h22, 8'h22, 8'h11, 8'h11};
      logic [7:0] t2b [4] = '{8'h66, 8'h55, 8'h66, 8'h55};
      bus.sew = 2'b01;
      for (int i = 0; i <= 4; i++) begin
         sb.push_back(lit("sew16_step", 2'(i % 4), 4'd0, t1a[i % 4], t1b[i % 4], t2a[i % 4], t2b[i % 4]));
         if (i == 0) begin
            #1;
            bus.enable_2bit = 1'b1;
         end else begin
            @(posedge clk);
            #1;
         end
         e = sb.pop_front();
         total++;
         if (snapshot() !== e.snap) $display("FAIL %s%0d: got %h expected %h", e.name, i, snapshot(), e.snap);
         else passed++;
`ifdef MULT_PRODUCT_EN
         total++;
         if ({bus.prod1, bus.prod2} !== {e.p1, e.p2})
            $display("FAIL %s%0d_prod: got %h expected %h", e.name, i, {bus.prod1, bus.prod2}, {e.p1, e.p2});
         else passed++;
`endif
      end
      bus.enable_2bit = 1'b0;
   endtask

   task automatic test_sew32();
      exp_t e;
      logic [3:0] kk;
      bus.sew = 2'b10;
      bus.enable_4bit = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         kk = 4'(i % 16);
         case (kk)
            4'd1:    sb.push_back(lit("sew32_k", 2'd0, kk, 8'h44, 8'h77, 8'h00, 8'h00));
            4'd6:    sb.push_back(lit("sew32_k", 2'd0, kk, 8'h33, 8'h66, 8'h00, 8'h00));
            4'd15:   sb.push_back(lit("sew32_k", 2'd0, kk, 8'h11, 8'h55, 8'h00, 8'h00));
            4'd0:    sb.push_back(lit("sew32_k", 2'd0, kk, 8'h44, 8'h88, 8'h00, 8'h00));
            default: sb.push_back(model("sew32_k", 2'b10, 2'd0, kk));
         endcase
         @(posedge clk);
         #1;
         e = sb.pop_front();
         total++;
         if (snapshot() !== e.snap) $display("FAIL %s%0d: got %h expected %h", e.name, kk, snapshot(), e.snap);
         else passed++;
`ifdef MULT_PRODUCT_EN
         total++;
         if ({bus.prod1, bus.prod2} !== {e.p1, e.p2})
            $display("FAIL %s%0d_prod: got %h expected %h", e.name, kk, {bus.prod1, bus.prod2}, {e.p1, e.p2});
         else passed++;
`endif
      end
      bus.enable_4bit = 1'b0;
   endtask

   task automatic test_mid_reset();
      exp_t e;
      bus.sew = 2'b10;
      bus.enable_4bit = 1'b1;
      for (int i = 1; i <= 11; i++) begin
         if (i <= 9)       sb.push_back(model("midrst_k", 2'b10, 2'd0, 4'(i)));
         else if (i == 10) sb.push_back(lit("midrst_async", 2'd0, 4'd0, 8'h44, 8'h88, 8'h00, 8'h00));
         else              sb.push_back(lit("midrst_release", 2'd0, 4'd1, 8'h44, 8'h77, 8'h00, 8'h00));
         if (i <= 9) begin
            @(posedge clk);
            #1;
         end else if (i == 10) begin
            #2 reset = 1'b1;   // well before the next rising edge
            #1;
         end else begin
            @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
            @(posedge clk);
            #1;
         end
         e = sb.pop_front();
         total++;
         if (snapshot() !== e.snap) $display("FAIL %s%0d: got %h expected %h", e.name, i, snapshot(), e.snap);
         else passed++;
`ifdef MULT_PRODUCT_EN
         total++;
         if ({bus.prod1, bus.prod2} !== {e.p1, e.p2})
            $display("FAIL %s%0d_prod: got %h expected %h", e.name, i, {bus.prod1, bus.prod2}, {e.p1, e.p2});
         else passed++;
`endif
      end
      bus.enable_4bit = 1'b0;
   endtask

   // Entry state: c=0, k=1. Both counters advance together, then sew is
   // switched without clocking to check immediate remapping.
   task automatic test_back_to_back();
      exp_t e;
      bus.sew = 2'b01;
      bus.enable_2bit = 1'b1;
      bus.enable_4bit = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         case (i)
            1:       sb.push_back(model("b2b_both", 2'b01, 2'd1, 4'd2));
            2:       sb.push_back(model("b2b_both", 2'b01, 2'd2, 4'd3));
            3:       sb.push_back(lit("b2b_sew8", 2'd2, 4'd3, 8'h44, 8'h88, 8'h33, 8'h77));
            4:       sb.push_back(lit("b2b_sew32", 2'd2, 4'd3, 8'h44, 8'h55, 8'h00, 8'h00));
            default: sb.push_back(lit("b2b_rsvd", 2'd2, 4'd3, 8'h00, 8'h00, 8'h00, 8'h00));
         endcase
         if (i <= 2) begin
            @(posedge clk);
            #1;
            if (i == 2) begin
               bus.enable_2bit = 1'b0;
               bus.enable_4bit = 1'b0;
            end
         end else begin
            bus.sew = (i == 3) ? 2'b00 : (i == 4) ? 2'b10 : 2'b11;
            #1;
         end
         e = sb.pop_front();
         total++;
         if (snapshot() !== e.snap) $display("FAIL %s%0d: got %h expected %h", e.name, i, snapshot(), e.snap);
         else passed++;
`ifdef MULT_PRODUCT_EN
         total++;
         if ({bus.prod1, bus.prod2} !== {e.p1, e.p2})
            $display("FAIL %s%0d_prod: got %h expected %h", e.name, i, {bus.prod1, bus.prod2}, {e.p1, e.p2});
         else passed++;
`endif
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_sew8();
      test_sew16();
      test_sew32();
      test_mid_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
